// File: rtl/step_period_meter.sv
// rtl/step_period_meter.sv - half-period meter for a step/square-wave input with valid/ack readout
// Counts in_clk cycles between successive edges of sig_in and holds the last result for software.
module step_period_meter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        in_clk,
    input  logic        reset,
    input  logic        sig_in,
    input  logic        ack,
    output logic [15:0] period_out,
    output logic [15:0] div_est,
    output logic        valid,
    output logic        overrun,
    output logic        stalled
);

    typedef enum logic [1:0] {
        WAIT_FIRST,
        MEASURE,
        STALLED
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_d;
    logic [15:0]            count;
    logic                   sig_edge;
    logic                   capture;

    assign sig_edge = sync_q[SYNC_STAGES-1] ^ sig_d;
    assign capture  = (state == MEASURE) && sig_edge;

    // A period below 2 can only come from an undivided input; report it as div 0.
    assign div_est = (period_out < 16'd2) ? 16'd0 : (period_out - 16'd2);

    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            sig_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sig_d  <= sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            state   <= WAIT_FIRST;
            count   <= 16'd0;
            stalled <= 1'b0;
        end else begin
            case (state)
                WAIT_FIRST: begin
                    if (sig_edge) begin
                        count <= 16'd1;
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (sig_edge) begin
                        count <= 16'd1;
                    end else if (count == 16'hFFFF) begin
                        state   <= STALLED;
                        stalled <= 1'b1;
                    end else begin
                        count <= count + 16'd1;
                    end
                end
                STALLED: begin
                    // The first edge after a stall only re-establishes a reference.
                    if (sig_edge) begin
                        count   <= 16'd1;
                        stalled <= 1'b0;
                        state   <= MEASURE;
                    end
                end
                default: begin
                    state <= WAIT_FIRST;
                end
            endcase
        end
    end

    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            period_out <= 16'd0;
            valid      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (capture) begin
                period_out <= count;
                valid      <= 1'b1;
            end else if (ack) begin
                valid <= 1'b0;
            end

            // An ack in the capture cycle consumes the old result, so it is not an overrun.
            if (ack && overrun) begin
                overrun <= 1'b0;
            end else if (capture && valid && !ack) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_step_period_meter.sv
// tb/tb_step_period_meter.sv - table-driven and scoreboard bench for step_period_meter
module tb_step_period_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        sig_in;
    logic        ack;
    logic [15:0] period_out;
    logic [15:0] div_est;
    logic        valid;
    logic        overrun;
    logic        stalled;

    step_period_meter #(.SYNC_STAGES(2)) dut (
        .in_clk     (clk),
        .reset      (rst),
        .sig_in     (sig_in),
        .ack        (ack),
        .period_out (period_out),
        .div_est    (div_est),
        .valid      (valid),
        .overrun    (overrun),
        .stalled    (stalled)
    );

    always #5 clk = ~clk;

    typedef struct {
        int half;
        int toggles;
        int exp_div;
    } vec_t;

    vec_t vecs[6];

    int  checks   = 0;
    int  errors   = 0;
    int  exp_q[$];
    int  half     = 0;
    int  gcnt     = 0;
    int  tog_left = -1;
    int  cur_div  = 0;
    bit  have_ref = 0;
    bit  auto_ack = 1;
    bit  ack_sent = 0;
    bit  first;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        int e;
        @(posedge clk);
        #1;
        if (ack_sent) begin
            ack      = 1'b0;
            ack_sent = 0;
            chk("valid_after_ack", int'(valid), 0);
        end else if (auto_ack && valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_result", int'(period_out), -1);
            end else begin
                e = exp_q.pop_front();
                chk("period_out", int'(period_out), e);
                chk("div_est", int'(div_est), cur_div);
                chk("overrun_clear", int'(overrun), 0);
            end
            ack      = 1'b1;
            ack_sent = 1;
        end
        if (half > 0) begin
            gcnt++;
            if (gcnt >= half) begin
                sig_in = ~sig_in;
                gcnt   = 0;
                if (have_ref) exp_q.push_back(half);
                have_ref = 1;
                if (tog_left > 0) begin
                    tog_left--;
                    if (tog_left == 0) half = 0;
                end
            end
        end
    endtask

    task automatic do_reset();
        #2;
        rst      = 1'b1;
        sig_in   = 1'b0;
        ack      = 1'b0;
        ack_sent = 0;
        #1;
        chk("rst_period_out", int'(period_out), 0);
        chk("rst_div_est", int'(div_est), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_stalled", int'(stalled), 0);
        exp_q.delete();
        half     = 0;
        gcnt     = 0;
        have_ref = 0;
        tog_left = -1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (valid) break;
            step();
        end
        chk("wait_valid", int'(valid), 1);
    endtask

    initial begin
        rst    = 1'b1;
        sig_in = 1'b0;
        ack    = 1'b0;

        vecs[0] = '{half: 5,  toggles: 4, exp_div: 3};
        vecs[1] = '{half: 12, toggles: 4, exp_div: 10};
        vecs[2] = '{half: 7,  toggles: 3, exp_div: 5};
        vecs[3] = '{half: 3,  toggles: 5, exp_div: 1};
        vecs[4] = '{half: 2,  toggles: 5, exp_div: 0};
        vecs[5] = '{half: 40, toggles: 3, exp_div: 38};

        // Free-running waveforms with software acking every result.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            auto_ack = 1;
            cur_div  = vecs[v].exp_div;
            tog_left = vecs[v].toggles;
            half     = vecs[v].half;
            for (int c = 0; c < vecs[v].half * (vecs[v].toggles + 1) + 20; c++) step();
            chk("queue_drained", exp_q.size(), 0);
        end

        // Toggle every cycle, never acked: result 1, div_est 0, overrun.
        do_reset();
        auto_ack = 0;
        half     = 1;
        tog_left = 4;
        repeat (12) step();
        chk("p1_period_out", int'(period_out), 1);
        chk("p1_div_est", int'(div_est), 0);
        chk("p1_overrun", int'(overrun), 1);

        // Overrun with div=2 and a single clearing ack.
        do_reset();
        auto_ack = 0;
        half     = 4;
        tog_left = 3;
        first    = 1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (valid && first) begin
                chk("ovr_first_capture", int'(overrun), 0);
                first = 0;
            end
        end
        chk("ovr_valid", int'(valid), 1);
        chk("ovr_overrun", int'(overrun), 1);
        chk("ovr_period_out", int'(period_out), 4);
        chk("ovr_div_est", int'(div_est), 2);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("ovr_ack_valid", int'(valid), 0);
        chk("ovr_ack_overrun", int'(overrun), 0);

        // Ack landing in the same cycle as a new capture (5 then 7).
        do_reset();
        auto_ack = 0;
        half     = 5;
        wait_valid(40);
        chk("sim_first_period", int'(period_out), 5);
        half = 7;
        repeat (6) step();
        ack = 1'b1;
        step();
        ack  = 1'b0;
        half = 0;
        chk("sim_valid", int'(valid), 1);
        chk("sim_overrun", int'(overrun), 0);
        chk("sim_period_out", int'(period_out), 7);
        chk("sim_div_est", int'(div_est), 5);
        step();
        chk("sim_valid_held", int'(valid), 1);

        // Stall after one measurement, then recovery at half-period 7.
        do_reset();
        auto_ack = 1;
        cur_div  = 5;
        half     = 7;
        tog_left = 2;
        repeat (30) step();
        chk("stall_pre_drained", exp_q.size(), 0);
        repeat (65000) step();
        chk("stall_not_early", int'(stalled), 0);
        for (int i = 0; i < 1000; i++) begin
            if (stalled) break;
            step();
        end
        chk("stall_set", int'(stalled), 1);
        chk("stall_period_kept", int'(period_out), 7);
        have_ref = 0;
        gcnt     = 0;
        half     = 7;
        tog_left = 3;
        repeat (40) step();
        chk("stall_recovered", int'(stalled), 0);
        chk("stall_post_drained", exp_q.size(), 0);

        // Reset three cycles after an edge in a div=20 run.
        do_reset();
        auto_ack = 0;
        half     = 22;
        wait_valid(100);
        chk("rmid_before", int'(period_out), 22);
        for (int i = 0; i < 50; i++) begin
            if (gcnt == 3) break;
            step();
        end
        do_reset();
        auto_ack = 1;
        cur_div  = 20;
        half     = 22;
        tog_left = 2;
        for (int c = 0; c < 22 * 3 + 20; c++) step();
        chk("rmid_drained", exp_q.size(), 0);
        chk("rmid_period_out", int'(period_out), 22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
